// File: rtl/msrv32_load_unit_hs.sv
// Handshaked load unit: word-aligned reads, byte/half/word extract and extend.
// Optional bus timeout when LU_TIMEOUT_EN is defined.
module msrv32_load_unit_hs #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        load_req_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [31:0] daddr_in,
    input  logic        flush_in,
    output logic        dmem_rd_req_out,
    output logic [31:0] dmem_addr_out,
    input  logic        dmem_rd_valid_in,
    input  logic [31:0] dmem_rdata_in,
    output logic [31:0] lu_output_out,
    output logic        lu_valid_out,
    output logic        stall_out,
    output logic        misaligned_out,
    output logic        bus_err_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t      state;
    logic [1:0]  cap_off;
    logic [1:0]  cap_size;
    logic        cap_uns;
    logic        accept;
    logic        mis;
    logic        issue;
    logic        timeout_hit;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic [31:0] ext_data;

    assign accept = load_req_in && !flush_in &&
                    (state == S_IDLE || state == S_DONE);
    assign mis    = (load_size_in == 2'b01 && daddr_in[0]) ||
                    (load_size_in[1] && daddr_in[1:0] != 2'b00);
    assign issue  = accept && !mis;

    assign stall_out = (state == S_WAIT) || issue ||
                       (state == S_DRAIN && load_req_in);

    always_comb begin
        sel_b    = dmem_rdata_in[7:0];
        sel_h    = cap_off[1] ? dmem_rdata_in[31:16]
                              : dmem_rdata_in[15:0];
        ext_data = dmem_rdata_in;
        unique case (cap_off)
            2'b00: sel_b = dmem_rdata_in[7:0];
            2'b01: sel_b = dmem_rdata_in[15:8];
            2'b10: sel_b = dmem_rdata_in[23:16];
            2'b11: sel_b = dmem_rdata_in[31:24];
        endcase
        unique case (1'b1)
            (cap_size == 2'b00):
                ext_data = {{24{sel_b[7] & ~cap_uns}}, sel_b};
            (cap_size == 2'b01):
                ext_data = {{16{sel_h[15] & ~cap_uns}}, sel_h};
            default:
                ext_data = dmem_rdata_in;
        endcase
    end

`ifdef LU_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt;

    assign timeout_hit = !dmem_rd_valid_in && (to_cnt == TO_LAST);

    // Cleared whenever WAIT or DRAIN is entered, counts idle bus cycles.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            to_cnt <= '0;
        end else if (issue ||
                     (state == S_WAIT && flush_in && !dmem_rd_valid_in)) begin
            to_cnt <= '0;
        end else if ((state == S_WAIT || state == S_DRAIN) &&
                     !dmem_rd_valid_in) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state           <= S_IDLE;
            cap_off         <= 2'b00;
            cap_size        <= 2'b00;
            cap_uns         <= 1'b0;
            dmem_rd_req_out <= 1'b0;
            dmem_addr_out   <= 32'h0;
            lu_output_out   <= 32'h0;
            lu_valid_out    <= 1'b0;
            misaligned_out  <= 1'b0;
            bus_err_out     <= 1'b0;
        end else begin
            lu_valid_out   <= 1'b0;
            misaligned_out <= 1'b0;
            bus_err_out    <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (issue) begin
                        cap_off         <= daddr_in[1:0];
                        cap_size        <= load_size_in;
                        cap_uns         <= load_unsigned_in;
                        dmem_addr_out   <= {daddr_in[31:2], 2'b00};
                        dmem_rd_req_out <= 1'b1;
                        state           <= S_WAIT;
                    end else if (accept) begin
                        misaligned_out <= 1'b1;
                        lu_output_out  <= 32'h0;
                    end
                end
                S_WAIT: begin
                    if (dmem_rd_valid_in) begin
                        dmem_rd_req_out <= 1'b0;
                        if (flush_in) begin
                            state <= S_IDLE;
                        end else begin
                            lu_output_out <= ext_data;
                            lu_valid_out  <= 1'b1;
                            state         <= S_DONE;
                        end
                    end else if (flush_in) begin
                        state <= S_DRAIN;
                    end else if (timeout_hit) begin
                        dmem_rd_req_out <= 1'b0;
                        bus_err_out     <= 1'b1;
                        lu_output_out   <= 32'h0;
                        state           <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    // Response to a flushed load is swallowed here.
                    if (dmem_rd_valid_in || timeout_hit) begin
                        dmem_rd_req_out <= 1'b0;
                        state           <= S_IDLE;
                        if (timeout_hit) begin
                            lu_output_out <= 32'h0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
